// File: rtl/trap_csr_pkg.sv
// Shared definitions for the trap CSR write sequencer: FSM states,
// trap command encoding, CSR addresses and status-register bit positions.
package trap_csr_pkg;

  // Sequencer states, one per CSR write slot plus idle and fence.i no-op
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_W_EPC    = 3'd1,
    ST_W_CAUSE  = 3'd2,
    ST_W_TVAL   = 3'd3,
    ST_W_STATUS = 3'd4,
    ST_W_PIP    = 3'd5,
    ST_W_RET    = 3'd6,
    ST_W_NOP    = 3'd7
  } state_t;

  // Trap command kinds as presented by the trap/interrupt logic
  typedef enum logic [1:0] {
    KIND_ENTRY = 2'd0,
    KIND_MRET  = 2'd1,
    KIND_SRET  = 2'd2,
    KIND_NOP   = 2'd3
  } trap_kind_t;

  // Machine-mode CSR addresses
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  // Supervisor-mode CSR addresses
  localparam logic [11:0] CSR_SSTATUS = 12'h100;
  localparam logic [11:0] CSR_SEPC    = 12'h141;
  localparam logic [11:0] CSR_SCAUSE  = 12'h142;
  localparam logic [11:0] CSR_STVAL   = 12'h143;
  localparam logic [11:0] CSR_SIP     = 12'h144;

  // mstatus / sstatus bit positions
  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MPP_HI   = 12;
  localparam int MPP_LO   = 11;
  localparam int SIE_BIT  = 1;
  localparam int SPIE_BIT = 5;
  localparam int SPP_BIT  = 8;

  // Trap entry into M-mode: stash MIE in MPIE, mask interrupts, record priv
  function automatic logic [31:0] entry_mstatus(input logic [31:0] s,
                                                input logic [1:0]  priv);
    logic [31:0] r;
    r                = s;
    r[MPIE_BIT]      = s[MIE_BIT];
    r[MIE_BIT]       = 1'b0;
    r[MPP_HI:MPP_LO] = priv;
    return r;
  endfunction

  // Trap entry into S-mode: stash SIE in SPIE, mask interrupts, record U/S
  function automatic logic [31:0] entry_sstatus(input logic [31:0] s,
                                                input logic        priv0);
    logic [31:0] r;
    r           = s;
    r[SPIE_BIT] = s[SIE_BIT];
    r[SIE_BIT]  = 1'b0;
    r[SPP_BIT]  = priv0;
    return r;
  endfunction

  // mret: restore MIE from MPIE, re-arm MPIE, drop MPP to user
  function automatic logic [31:0] mret_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r                = s;
    r[MIE_BIT]       = s[MPIE_BIT];
    r[MPIE_BIT]      = 1'b1;
    r[MPP_HI:MPP_LO] = 2'b00;
    return r;
  endfunction

  // sret: restore SIE from SPIE, re-arm SPIE, drop SPP to user
  function automatic logic [31:0] sret_sstatus(input logic [31:0] s);
    logic [31:0] r;
    r           = s;
    r[SIE_BIT]  = s[SPIE_BIT];
    r[SPIE_BIT] = 1'b1;
    r[SPP_BIT]  = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/trap_csr_seq.sv
// Trap CSR write sequencer. Owns the single CSR write port during trap
// entry/return, issuing one write per cycle. WB-stage CSR instruction
// writes always win the port and stall the sequence for that cycle.
module trap_csr_seq
  import trap_csr_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_valid_i,
  output logic        trap_ready_o,
  input  logic [1:0]  trap_kind_i,
  input  logic        trap_deleg_i,
  input  logic        trap_irq_i,
  input  logic [31:0] trap_epc_i,
  input  logic [31:0] trap_cause_i,
  input  logic [31:0] trap_tval_i,
  input  logic [1:0]  priv_i,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] sstatus_i,
  input  logic [31:0] mip_i,
  input  logic [31:0] sip_i,
  input  logic        wb_csr_we_i,
  input  logic [11:0] wb_csr_addr_i,
  input  logic [31:0] wb_csr_wdata_i,
  output logic        csr_we_o,
  output logic [11:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        busy_o,
  output logic        done_o
);

  state_t      state_q;
  state_t      state_d;
  state_t      fsm_next;
  trap_kind_t  kind_q;
  logic        deleg_q;
  logic        irq_q;
  logic [31:0] epc_q;
  logic [31:0] cause_q;
  logic [31:0] tval_q;
  logic [1:0]  priv_q;

  logic        accept;
  logic        fsm_we;
  logic [11:0] fsm_addr;
  logic [31:0] fsm_data;
  logic        fsm_last;

  // A command is taken whenever it is offered while idle, even if WB owns
  // the port this cycle: the first trap write only issues next cycle.
  assign accept = trap_valid_i && (state_q == ST_IDLE);

  // State register; reset drops any in-flight sequence immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Snapshot the trap command on accept so later input changes are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kind_q  <= KIND_ENTRY;
      deleg_q <= 1'b0;
      irq_q   <= 1'b0;
      epc_q   <= 32'd0;
      cause_q <= 32'd0;
      tval_q  <= 32'd0;
      priv_q  <= 2'd0;
    end else if (accept) begin
      kind_q  <= trap_kind_t'(trap_kind_i);
      deleg_q <= trap_deleg_i;
      irq_q   <= trap_irq_i;
      epc_q   <= trap_epc_i;
      cause_q <= trap_cause_i;
      tval_q  <= trap_tval_i;
      priv_q  <= priv_i;
    end
  end

  // Per-state write selection and the successor state assuming no WB stall
  always_comb begin
    fsm_next = state_q;
    fsm_we   = 1'b0;
    fsm_addr = 12'd0;
    fsm_data = 32'd0;
    fsm_last = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (trap_kind_t'(trap_kind_i))
            KIND_ENTRY: fsm_next = ST_W_EPC;
            KIND_MRET:  fsm_next = ST_W_RET;
            KIND_SRET:  fsm_next = ST_W_RET;
            default:    fsm_next = ST_W_NOP;
          endcase
        end
      end
      ST_W_EPC: begin
        fsm_we   = 1'b1;
        fsm_addr = deleg_q ? CSR_SEPC : CSR_MEPC;
        fsm_data = epc_q;
        fsm_next = ST_W_CAUSE;
      end
      ST_W_CAUSE: begin
        fsm_we   = 1'b1;
        fsm_addr = deleg_q ? CSR_SCAUSE : CSR_MCAUSE;
        fsm_data = cause_q;
        fsm_next = ST_W_TVAL;
      end
      ST_W_TVAL: begin
        fsm_we   = 1'b1;
        fsm_addr = deleg_q ? CSR_STVAL : CSR_MTVAL;
        fsm_data = tval_q;
        fsm_next = ST_W_STATUS;
      end
      ST_W_STATUS: begin
        fsm_we   = 1'b1;
        fsm_addr = deleg_q ? CSR_SSTATUS : CSR_MSTATUS;
        fsm_data = deleg_q ? entry_sstatus(sstatus_i, priv_q[0])
                           : entry_mstatus(mstatus_i, priv_q);
        fsm_next = irq_q ? ST_W_PIP : ST_IDLE;
        fsm_last = !irq_q;
      end
      ST_W_PIP: begin
        fsm_we   = 1'b1;
        fsm_addr = deleg_q ? CSR_SIP : CSR_MIP;
        fsm_data = (deleg_q ? sip_i : mip_i) | (32'd1 << cause_q[4:0]);
        fsm_next = ST_IDLE;
        fsm_last = 1'b1;
      end
      ST_W_RET: begin
        fsm_we   = 1'b1;
        if (kind_q == KIND_SRET) begin
          fsm_addr = CSR_SSTATUS;
          fsm_data = sret_sstatus(sstatus_i);
        end else begin
          fsm_addr = CSR_MSTATUS;
          fsm_data = mret_mstatus(mstatus_i);
        end
        fsm_next = ST_IDLE;
        fsm_last = 1'b1;
      end
      ST_W_NOP: begin
        fsm_next = ST_IDLE;
        fsm_last = 1'b1;
      end
      default: begin
        fsm_next = ST_IDLE;
      end
    endcase
  end

  // A WB write steals the port, so a busy sequence holds its slot
  always_comb begin
    state_d = fsm_next;
    if (wb_csr_we_i && (state_q != ST_IDLE)) begin
      state_d = state_q;
    end
  end

  // Port mux and status outputs; everything reads zero while in reset
  always_comb begin
    csr_we_o     = 1'b0;
    csr_waddr_o  = 12'd0;
    csr_wdata_o  = 32'd0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    trap_ready_o = 1'b0;
    if (!rst) begin
      busy_o       = (state_q != ST_IDLE);
      trap_ready_o = (state_q == ST_IDLE);
      if (wb_csr_we_i) begin
        csr_we_o    = 1'b1;
        csr_waddr_o = wb_csr_addr_i;
        csr_wdata_o = wb_csr_wdata_i;
      end else begin
        csr_we_o    = fsm_we;
        csr_waddr_o = fsm_addr;
        csr_wdata_o = fsm_data;
        done_o      = fsm_last;
      end
    end
  end

endmodule

// File: tb/tb_trap_csr_seq.sv
// Self-checking bench for trap_csr_seq: expected CSR port writes go into a
// scoreboard queue as each scenario is driven and are matched by a monitor.
module tb_trap_csr_seq;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_valid_i;
  logic        trap_ready_o;
  logic [1:0]  trap_kind_i;
  logic        trap_deleg_i;
  logic        trap_irq_i;
  logic [31:0] trap_epc_i;
  logic [31:0] trap_cause_i;
  logic [31:0] trap_tval_i;
  logic [1:0]  priv_i;
  logic [31:0] mstatus_i;
  logic [31:0] sstatus_i;
  logic [31:0] mip_i;
  logic [31:0] sip_i;
  logic        wb_csr_we_i;
  logic [11:0] wb_csr_addr_i;
  logic [31:0] wb_csr_wdata_i;
  logic        csr_we_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        busy_o;
  logic        done_o;

  int  checks = 0;
  int  errors = 0;
  wr_t exp_q[$];

  trap_csr_seq dut (
    .clk            (clk),
    .rst            (rst),
    .trap_valid_i   (trap_valid_i),
    .trap_ready_o   (trap_ready_o),
    .trap_kind_i    (trap_kind_i),
    .trap_deleg_i   (trap_deleg_i),
    .trap_irq_i     (trap_irq_i),
    .trap_epc_i     (trap_epc_i),
    .trap_cause_i   (trap_cause_i),
    .trap_tval_i    (trap_tval_i),
    .priv_i         (priv_i),
    .mstatus_i      (mstatus_i),
    .sstatus_i      (sstatus_i),
    .mip_i          (mip_i),
    .sip_i          (sip_i),
    .wb_csr_we_i    (wb_csr_we_i),
    .wb_csr_addr_i  (wb_csr_addr_i),
    .wb_csr_wdata_i (wb_csr_wdata_i),
    .csr_we_o       (csr_we_o),
    .csr_waddr_o    (csr_waddr_o),
    .csr_wdata_o    (csr_wdata_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  // 10-unit clock
  always #5 clk = ~clk;

  // Scoreboard monitor: every port write must match the oldest expectation
  always @(negedge clk) begin
    if (csr_we_o === 1'b1) begin
      wr_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL port_write_unexpected: got addr %h data %h, none expected",
                 csr_waddr_o, csr_wdata_o);
      end else begin
        e = exp_q.pop_front();
        if ({csr_waddr_o, csr_wdata_o} !== {e.addr, e.data}) begin
          errors++;
          $display("[TB] FAIL port_write: got addr %h data %h, want addr %h data %h",
                   csr_waddr_o, csr_wdata_o, e.addr, e.data);
        end
      end
    end
  end

  // Safety net so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, want finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void push_wr(input logic [11:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endfunction

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({csr_we_o, csr_waddr_o, csr_wdata_o, busy_o, done_o, trap_ready_o} !== 48'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got we %b addr %h data %h busy %b done %b ready %b, want all 0",
               csr_we_o, csr_waddr_o, csr_wdata_o, busy_o, done_o, trap_ready_o);
    end
    next_cycle;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({trap_ready_o, busy_o, csr_we_o} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL reset_release: got ready %b busy %b we %b, want 1 0 0",
               trap_ready_o, busy_o, csr_we_o);
    end
  endtask

  task automatic test_wb_idle;
    next_cycle;
    wb_csr_we_i    = 1'b1;
    wb_csr_addr_i  = 12'h305;
    wb_csr_wdata_i = 32'h0000_1234;
    push_wr(12'h305, 32'h0000_1234);
    @(negedge clk);
    checks++;
    if ({busy_o, done_o} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL wb_idle_flags: got busy %b done %b, want 0 0", busy_o, done_o);
    end
    next_cycle;
    wb_csr_we_i = 1'b0;
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL wb_idle_drain: got %0d pending writes, want 0", exp_q.size());
    end
  endtask

  task automatic test_m_ecall;
    logic eb, ed, er;
    next_cycle;
    trap_valid_i = 1'b1; trap_kind_i = 2'd0; trap_deleg_i = 1'b0; trap_irq_i = 1'b0;
    trap_epc_i = 32'h8000_0010; trap_cause_i = 32'd11; trap_tval_i = 32'd0;
    priv_i = 2'd3; mstatus_i = 32'h8;
    push_wr(12'h341, 32'h8000_0010);
    push_wr(12'h342, 32'h0000_000B);
    push_wr(12'h343, 32'h0000_0000);
    push_wr(12'h300, 32'h0000_1880);
    for (int k = 1; k <= 5; k++) begin
      next_cycle;
      if (k == 1) begin
        trap_valid_i = 1'b0; trap_epc_i = 32'hDEAD_BEEF; trap_cause_i = 32'h7;
        trap_tval_i = 32'h5555_5555; priv_i = 2'd0; trap_deleg_i = 1'b1;
      end
      @(negedge clk);
      eb = (k <= 4); ed = (k == 4); er = (k == 5);
      checks++;
      if ({busy_o, done_o, trap_ready_o} !== {eb, ed, er}) begin
        errors++;
        $display("[TB] FAIL ecall_flags N+%0d: got busy %b done %b ready %b, want %b %b %b",
                 k, busy_o, done_o, trap_ready_o, eb, ed, er);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL ecall_drain: got %0d pending writes, want 0", exp_q.size());
    end
    trap_deleg_i = 1'b0;
  endtask

  task automatic test_s_irq;
    logic eb, ed, er;
    next_cycle;
    trap_valid_i = 1'b1; trap_kind_i = 2'd0; trap_deleg_i = 1'b1; trap_irq_i = 1'b1;
    trap_epc_i = 32'h0000_4000; trap_cause_i = 32'h8000_0005; trap_tval_i = 32'h0000_00AB;
    priv_i = 2'd0; sstatus_i = 32'h2; sip_i = 32'h0;
    push_wr(12'h141, 32'h0000_4000);
    push_wr(12'h142, 32'h8000_0005);
    push_wr(12'h143, 32'h0000_00AB);
    push_wr(12'h100, 32'h0000_0020);
    push_wr(12'h144, 32'h0000_0020);
    for (int k = 1; k <= 6; k++) begin
      next_cycle;
      if (k == 1) begin
        trap_valid_i = 1'b0; trap_irq_i = 1'b0; trap_cause_i = 32'h0;
      end
      @(negedge clk);
      eb = (k <= 5); ed = (k == 5); er = (k == 6);
      checks++;
      if ({busy_o, done_o, trap_ready_o} !== {eb, ed, er}) begin
        errors++;
        $display("[TB] FAIL s_irq_flags N+%0d: got busy %b done %b ready %b, want %b %b %b",
                 k, busy_o, done_o, trap_ready_o, eb, ed, er);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL s_irq_drain: got %0d pending writes, want 0", exp_q.size());
    end
    trap_deleg_i = 1'b0;
  endtask

  task automatic test_wb_conflict;
    logic eb, ed;
    next_cycle;
    trap_valid_i = 1'b1; trap_kind_i = 2'd0; trap_deleg_i = 1'b0; trap_irq_i = 1'b0;
    trap_epc_i = 32'h8000_0020; trap_cause_i = 32'd2; trap_tval_i = 32'h0000_0013;
    priv_i = 2'd3; mstatus_i = 32'h8;
    push_wr(12'h341, 32'h8000_0020);
    push_wr(12'h305, 32'h8000_0100);
    push_wr(12'h342, 32'h0000_0002);
    push_wr(12'h343, 32'h0000_0013);
    push_wr(12'h300, 32'h0000_1880);
    for (int k = 1; k <= 6; k++) begin
      next_cycle;
      if (k == 1) trap_valid_i = 1'b0;
      if (k == 2) begin
        wb_csr_we_i = 1'b1; wb_csr_addr_i = 12'h305; wb_csr_wdata_i = 32'h8000_0100;
      end
      if (k == 3) wb_csr_we_i = 1'b0;
      @(negedge clk);
      eb = (k <= 5); ed = (k == 5);
      checks++;
      if ({busy_o, done_o} !== {eb, ed}) begin
        errors++;
        $display("[TB] FAIL wb_conflict_flags N+%0d: got busy %b done %b, want %b %b",
                 k, busy_o, done_o, eb, ed);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL wb_conflict_drain: got %0d pending writes, want 0", exp_q.size());
    end
  endtask

  task automatic test_returns;
    // mret then sret, each done one cycle after accept
    for (int r = 0; r < 2; r++) begin
      next_cycle;
      trap_valid_i = 1'b1;
      trap_kind_i  = (r == 0) ? 2'd1 : 2'd2;
      mstatus_i    = 32'h1880;
      sstatus_i    = 32'h120;
      if (r == 0) push_wr(12'h300, 32'h0000_0088);
      else        push_wr(12'h100, 32'h0000_0022);
      next_cycle;
      trap_valid_i = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy_o, done_o, trap_ready_o} !== 3'b110) begin
        errors++;
        $display("[TB] FAIL ret%0d_n1: got busy %b done %b ready %b, want 1 1 0",
                 r, busy_o, done_o, trap_ready_o);
      end
      next_cycle;
      @(negedge clk);
      checks++;
      if ({busy_o, done_o, trap_ready_o} !== 3'b001) begin
        errors++;
        $display("[TB] FAIL ret%0d_n2: got busy %b done %b ready %b, want 0 0 1",
                 r, busy_o, done_o, trap_ready_o);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL ret_drain: got %0d pending writes, want 0", exp_q.size());
    end
  endtask

  task automatic test_nop;
    logic ed, er;
    next_cycle;
    trap_valid_i = 1'b1; trap_kind_i = 2'd3;
    for (int k = 1; k <= 2; k++) begin
      next_cycle;
      trap_valid_i = 1'b0;
      @(negedge clk);
      ed = (k == 1); er = (k == 2);
      checks++;
      if ({csr_we_o, done_o, trap_ready_o} !== {1'b0, ed, er}) begin
        errors++;
        $display("[TB] FAIL nop N+%0d: got we %b done %b ready %b, want 0 %b %b",
                 k, csr_we_o, done_o, trap_ready_o, ed, er);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic eb, ed, er;
    next_cycle;
    trap_valid_i = 1'b1; trap_kind_i = 2'd1; mstatus_i = 32'h1880;
    push_wr(12'h300, 32'h0000_0088);
    push_wr(12'h300, 32'h0000_0088);
    for (int k = 1; k <= 4; k++) begin
      next_cycle;
      if (k == 3) trap_valid_i = 1'b0;
      @(negedge clk);
      eb = (k == 1) || (k == 3); ed = eb; er = (k == 2) || (k == 4);
      checks++;
      if ({busy_o, done_o, trap_ready_o} !== {eb, ed, er}) begin
        errors++;
        $display("[TB] FAIL b2b N+%0d: got busy %b done %b ready %b, want %b %b %b",
                 k, busy_o, done_o, trap_ready_o, eb, ed, er);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL b2b_drain: got %0d pending writes, want 0", exp_q.size());
    end
  endtask

  task automatic test_mid_reset;
    next_cycle;
    trap_valid_i = 1'b1; trap_kind_i = 2'd0; trap_deleg_i = 1'b0; trap_irq_i = 1'b1;
    trap_epc_i = 32'h8000_0040; trap_cause_i = 32'd5; trap_tval_i = 32'd0;
    priv_i = 2'd1; mstatus_i = 32'h8;
    push_wr(12'h341, 32'h8000_0040);
    next_cycle;
    trap_valid_i = 1'b0;
    next_cycle;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({csr_we_o, busy_o, done_o} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL mid_reset: got we %b busy %b done %b, want 0 0 0",
               csr_we_o, busy_o, done_o);
    end
    next_cycle;
    rst = 1'b0;
    trap_valid_i = 1'b1; trap_kind_i = 2'd3;
    @(negedge clk);
    checks++;
    if ({trap_ready_o, busy_o} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL post_reset_ready: got ready %b busy %b, want 1 0", trap_ready_o, busy_o);
    end
    next_cycle;
    trap_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({done_o, busy_o} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL post_reset_accept: got done %b busy %b, want 1 1", done_o, busy_o);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL mid_reset_drain: got %0d pending writes, want 0", exp_q.size());
    end
  endtask

  // Main sequence
  initial begin
    rst = 1'b1;
    trap_valid_i = 1'b0; trap_kind_i = 2'd0; trap_deleg_i = 1'b0; trap_irq_i = 1'b0;
    trap_epc_i = 32'd0; trap_cause_i = 32'd0; trap_tval_i = 32'd0; priv_i = 2'd0;
    mstatus_i = 32'd0; sstatus_i = 32'd0; mip_i = 32'd0; sip_i = 32'd0;
    wb_csr_we_i = 1'b0; wb_csr_addr_i = 12'd0; wb_csr_wdata_i = 32'd0;

    test_reset;
    test_wb_idle;
    test_m_ecall;
    test_s_irq;
    test_wb_conflict;
    test_returns;
    test_nop;
    test_back_to_back;
    test_mid_reset;

    next_cycle;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
